// File: rtl/limn2600_cache_fill_if.sv
// Ports of the line-fill block: fetch request/response, memory read bus and cache key/data ports.
interface limn2600_cache_fill_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic        cache_we;
    logic [31:0] cache_addr_in;
    logic [31:0] cache_data_in;
    logic [31:0] cache_addr_out;
    logic [31:0] cache_data_out;

    // master is the fill block, slave is the fetch unit / memory / cache around it
    modport master (
        input  req_valid, req_addr, resp_ready, inv, mem_ack, mem_err, mem_rdata, cache_data_out,
        output req_ready, resp_valid, resp_data, resp_err, mem_req, mem_addr,
               cache_we, cache_addr_in, cache_data_in, cache_addr_out
    );
    modport slave (
        output req_valid, req_addr, resp_ready, inv, mem_ack, mem_err, mem_rdata, cache_data_out,
        input  req_ready, resp_valid, resp_data, resp_err, mem_req, mem_addr,
               cache_we, cache_addr_in, cache_data_in, cache_addr_out
    );
endinterface

// File: rtl/limn2600_cache_fill.sv
// Single-line instruction fetch fill engine: hits read the downstream cache, misses
// burst a whole line from memory into it, with timeout/bus-error abort and invalidate.
module limn2600_cache_fill #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                  clk,
    input logic                  rst,
    limn2600_cache_fill_if.master bus
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = 30 - OFF_W;
    localparam int unsigned TO_W  = 8;

    typedef enum logic [2:0] {IDLE, RD0, RD1, FILL, RESP} state_t;

    state_t           state;
    logic [TAG_W-1:0] line_tag;
    logic             line_valid;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] beat;
    logic [TO_W-1:0]  tcnt;
    logic             inv_seen;

    logic             accept;
    logic             hit;
    logic             beat_ok;
    logic             last_beat;
    logic             timed_out;
    logic [TAG_W-1:0] in_tag;
    logic [OFF_W-1:0] beat_nxt;
    logic             unused_addr_lsb;

    assign in_tag          = bus.req_addr[31:OFF_W+2];
    assign accept          = (state == IDLE) && bus.req_ready && bus.req_valid;
    assign hit             = line_valid && (in_tag == line_tag);
    assign beat_ok         = (state == FILL) && bus.mem_ack && !bus.mem_err;
    assign last_beat       = (beat == OFF_W'(LINE_WORDS - 1));
    assign timed_out       = (tcnt == TO_W'(TIMEOUT - 1));
    assign beat_nxt        = beat + OFF_W'(1);
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // The cache write must land in the same cycle as the memory ack, so these follow mem_ack directly.
    assign bus.cache_we      = beat_ok;
    assign bus.cache_addr_in = beat_ok ? bus.mem_addr  : 32'h0;
    assign bus.cache_data_in = beat_ok ? bus.mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            line_tag           <= '0;
            line_valid         <= 1'b0;
            req_tag            <= '0;
            req_off            <= '0;
            beat               <= '0;
            tcnt               <= '0;
            inv_seen           <= 1'b0;
            bus.req_ready      <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_data      <= 32'h0;
            bus.resp_err       <= 1'b0;
            bus.mem_req        <= 1'b0;
            bus.mem_addr       <= 32'h0;
            bus.cache_addr_out <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        req_tag       <= in_tag;
                        req_off       <= bus.req_addr[OFF_W+1:2];
                        inv_seen      <= 1'b0;
                        if (hit) begin
                            state              <= RD0;
                            bus.cache_addr_out <= {bus.req_addr[31:2], 2'b00};
                        end else begin
                            state        <= FILL;
                            beat         <= '0;
                            tcnt         <= '0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {in_tag, OFF_W'(0), 2'b00};
                        end
                    end
                end
                RD0: state <= RD1;
                RD1: begin
                    state          <= RESP;
                    bus.resp_data  <= bus.cache_data_out;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                end
                FILL: begin
                    if (bus.inv) begin
                        inv_seen <= 1'b1;
                    end
                    // Bus error outranks a simultaneous ack; silence for TIMEOUT cycles also aborts.
                    if (bus.mem_err || (!bus.mem_ack && timed_out)) begin
                        state          <= RESP;
                        bus.mem_req    <= 1'b0;
                        line_valid     <= 1'b0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_data  <= 32'h0;
                        bus.resp_valid <= 1'b1;
                    end else if (bus.mem_ack) begin
                        tcnt <= '0;
                        if (beat == req_off) begin
                            bus.resp_data <= bus.mem_rdata;
                        end
                        if (last_beat) begin
                            state          <= RESP;
                            bus.mem_req    <= 1'b0;
                            bus.resp_err   <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            line_tag       <= req_tag;
                            line_valid     <= !(inv_seen || bus.inv);
                        end else begin
                            beat         <= beat_nxt;
                            bus.mem_addr <= {req_tag, beat_nxt, 2'b00};
                        end
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate wins over a line record update in the same cycle.
            if (bus.inv) begin
                line_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_limn2600_cache_fill.sv
// Directed bench for limn2600_cache_fill: a transaction-level model of the line record and
// expected responses is compared against the DUT every cycle, plus literal spot checks.
module tb_limn2600_cache_fill;
    localparam int unsigned LW = 4;
    localparam int unsigned TO = 255;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_we   = 0;
    int   n_mreq = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    limn2600_cache_fill_if bus ();
    limn2600_cache_fill #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream cache: write on cache_we, registered read one edge after the key is sampled.
    logic [31:0] cmem [logic [31:0]];
    always @(posedge clk) begin
        if (bus.cache_we) cmem[bus.cache_addr_in] = bus.cache_data_in;
        bus.cache_data_out <= cmem.exists(bus.cache_addr_out) ? cmem[bus.cache_addr_out] : 32'h0;
    end

    // Memory responder: ack after rsp_delay idle cycles per beat, error on beat rsp_err_beat.
    int rsp_delay    = 0;
    int rsp_err_beat = -1;
    bit rsp_silent   = 1'b0;
    initial begin
        int w;
        int b;
        w = 0;
        b = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack   = 1'b0;
            bus.mem_err   = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            if (!bus.mem_req) begin
                w = 0;
                b = 0;
            end else if (!rsp_silent) begin
                if (w >= rsp_delay) begin
                    w = 0;
                    if (b == rsp_err_beat) bus.mem_err = 1'b1;
                    else begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_word(bus.mem_addr);
                    end
                    b++;
                end else w++;
            end
        end
    end

    // Reference model: line record, outstanding transaction and expected response.
    bit          m_ready, m_lv, m_fill, m_resp, m_rerr, m_invp;
    logic [31:0] m_ltag, m_base, m_addr, m_rdata;
    int          m_hw, m_beat, m_off, m_wait;

    task automatic m_abort();
        m_fill  = 1'b0;
        m_resp  = 1'b1;
        m_rerr  = 1'b1;
        m_rdata = 32'h0;
        m_lv    = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0; m_lv = 1'b0; m_fill = 1'b0; m_resp = 1'b0; m_rerr = 1'b0;
            m_invp = 1'b0; m_ltag = 32'h0; m_hw = 0; m_beat = 0; m_wait = 0; m_rdata = 32'h0;
        end else begin
            if (m_ready && bus.req_valid) begin
                m_ready = 1'b0;
                m_addr  = bus.req_addr & 32'hFFFF_FFFC;
                if (m_lv && ((m_addr & LINE_MASK) == m_ltag)) m_hw = 2;
                else begin
                    m_fill = 1'b1; m_beat = 0; m_wait = 0; m_invp = 1'b0;
                    m_base = m_addr & LINE_MASK;
                    m_off  = int'((m_addr >> 2) % LW);
                end
            end else if (m_hw > 0) begin
                m_hw--;
                if (m_hw == 0) begin
                    m_resp  = 1'b1;
                    m_rerr  = 1'b0;
                    m_rdata = cmem.exists(m_addr) ? cmem[m_addr] : 32'h0;
                end
            end else if (m_fill) begin
                if (bus.inv) m_invp = 1'b1;
                if (bus.mem_err) m_abort();
                else if (bus.mem_ack) begin
                    if (m_beat == m_off) m_rdata = bus.mem_rdata;
                    m_wait = 0;
                    if (m_beat == int'(LW) - 1) begin
                        m_fill = 1'b0; m_resp = 1'b1; m_rerr = 1'b0;
                        m_ltag = m_base;
                        m_lv   = !m_invp;
                    end else m_beat++;
                end else begin
                    m_wait++;
                    if (m_wait == int'(TO)) m_abort();
                end
            end else if (m_resp) begin
                if (bus.resp_ready) begin
                    m_resp  = 1'b0;
                    m_ready = 1'b1;
                end
            end else m_ready = 1'b1;
            if (bus.inv) m_lv = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
        chk("mem_req", 32'(bus.mem_req), 32'(m_fill));
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
        chk("resp_err", 32'(bus.resp_err), 32'(m_resp && m_rerr));
        chk("cache_we", 32'(bus.cache_we), 32'(rst && m_fill && bus.mem_ack && !bus.mem_err));
        if (m_fill) chk("mem_addr", bus.mem_addr, m_base + 32'(4 * m_beat));
        if (m_fill && bus.cache_we) begin
            chk("cache_addr_in", bus.cache_addr_in, m_base + 32'(4 * m_beat));
            chk("cache_data_in", bus.cache_data_in, bus.mem_rdata);
        end
        if (m_resp) chk("resp_data", bus.resp_data, m_rdata);
        if (m_hw > 0) chk("cache_addr_out", bus.cache_addr_out, m_addr);
        n_we   += int'(bus.cache_we);
        n_mreq += int'(bus.mem_req);
    end

    task automatic do_req(input logic [31:0] a, input bit with_inv);
        int k;
        k = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.inv       = with_inv;
        while (k < 50) begin
            @(negedge clk);
            if (bus.req_ready) break;
            k++;
        end
        chk("req_accepted", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.inv       = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [31:0] exp_data, input logic exp_err,
                            input int hold, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 400);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_data"}, bus.resp_data, exp_data);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, "_hold_data"}, bus.resp_data, exp_data);
            chk({tag, "_hold_err"}, 32'(bus.resp_err), 32'(exp_err));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int we0;
        int mq0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.resp_ready = 1'b0; bus.inv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_cache_addr_in", bus.cache_addr_in, 32'h0);
        chk("rst_cache_addr_out", bus.cache_addr_out, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Miss on 0x1008: whole line fetched, requested word returned.
        rsp_delay = 1; we0 = n_we;
        do_req(32'h1008, 1'b0);
        get_resp("miss1008", 32'hC0DE_1008, 1'b0, 0, lat);
        chk("miss1008_writes", 32'(n_we - we0), 32'd4);

        // Hit on 0x1004: cache read, three-cycle latency, no memory traffic.
        we0 = n_we; mq0 = n_mreq;
        do_req(32'h1004, 1'b0);
        get_resp("hit1004", 32'hC0DE_1004, 1'b0, 0, lat);
        chk("hit1004_latency", 32'(lat), 32'd3);
        chk("hit1004_memreq", 32'(n_mreq - mq0), 32'd0);
        chk("hit1004_writes", 32'(n_we - we0), 32'd0);

        // Bus error on beat 2 of line 0x1010.
        rsp_delay = 0; rsp_err_beat = 2; we0 = n_we;
        do_req(32'h1014, 1'b0);
        get_resp("err", 32'h0, 1'b1, 0, lat);
        chk("err_writes", 32'(n_we - we0), 32'd2);
        rsp_err_beat = -1;

        // Line record cleared by the abort: 0x1000 misses again.
        we0 = n_we; mq0 = n_mreq;
        do_req(32'h1000, 1'b0);
        get_resp("remiss1000", 32'hC0DE_1000, 1'b0, 0, lat);
        chk("remiss1000_writes", 32'(n_we - we0), 32'd4);
        chk("remiss1000_memreq", 32'(n_mreq - mq0), 32'd4);

        // Silent memory: abort after 255 cycles, response held while resp_ready is low.
        rsp_silent = 1'b1; we0 = n_we; mq0 = n_mreq;
        do_req(32'h4000, 1'b0);
        get_resp("timeout", 32'h0, 1'b1, 10, lat);
        chk("timeout_cycles", 32'(n_mreq - mq0), 32'd255);
        chk("timeout_writes", 32'(n_we - we0), 32'd0);
        rsp_silent = 1'b0;

        // Invalidate during the fill of 0x2000: all beats written, line stays invalid.
        rsp_delay = 2; we0 = n_we;
        do_req(32'h2000, 1'b0);
        repeat (2) @(posedge clk);
        #1 bus.inv = 1'b1;
        @(posedge clk);
        #1 bus.inv = 1'b0;
        get_resp("invfill", 32'hC0DE_2000, 1'b0, 0, lat);
        chk("invfill_writes", 32'(n_we - we0), 32'd4);
        we0 = n_we;
        do_req(32'h2000, 1'b0);
        get_resp("miss2000", 32'hC0DE_2000, 1'b0, 0, lat);
        chk("miss2000_writes", 32'(n_we - we0), 32'd4);

        // Hit accepted together with inv uses the old line_valid; the next one misses.
        we0 = n_we; mq0 = n_mreq;
        do_req(32'h2008, 1'b1);
        get_resp("hitinv", 32'hC0DE_2008, 1'b0, 0, lat);
        chk("hitinv_latency", 32'(lat), 32'd3);
        chk("hitinv_memreq", 32'(n_mreq - mq0), 32'd0);
        we0 = n_we;
        do_req(32'h2008, 1'b0);
        get_resp("postinv", 32'hC0DE_2008, 1'b0, 0, lat);
        chk("postinv_writes", 32'(n_we - we0), 32'd4);

        // Reset in the middle of a burst: memory request and cache write drop at once.
        rsp_delay = 0;
        do_req(32'h5000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_ack_driven", 32'(bus.mem_ack), 32'd1);
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_cache_we", 32'(bus.cache_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        we0 = n_we;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) @(posedge clk);
        chk("midrst_no_writes", 32'(n_we - we0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/limn2600_cache_fill.md
LIMN2600_CACHE_FILL -- requirements
Module: limn2600_cache_fill

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per line fill; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255, max cycles to wait for mem_ack per beat; 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low = in reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_addr  input  32  fetch byte address; bits [1:0] ignored, treated as 0.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 resp_valid  output  1  response present.
REQ-009 resp_ready  input  1  consumer takes the response.
REQ-010 resp_data  output  32  fetched word.
REQ-011 resp_err  output  1  fetch failed; resp_data is 0.
REQ-012 inv  input  1  single-cycle pulse that invalidates the line record.
REQ-013 mem_req  output  1  memory read request, held until mem_ack or abort.
REQ-014 mem_addr  output  32  word-aligned memory read address.
REQ-015 mem_ack  input  1  mem_rdata valid this cycle; beat complete.
REQ-016 mem_err  input  1  bus error this cycle; beat failed.
REQ-017 mem_rdata  input  32  memory read data.
REQ-018 cache_we  output  1  write strobe to the downstream cache.
REQ-019 cache_addr_in  output  32  cache write key.
REQ-020 cache_data_in  output  32  cache write data.
REQ-021 cache_addr_out  output  32  cache read key.
REQ-022 cache_data_out  input  32  cache read data, registered by the cache one edge after cache_addr_out is sampled.

Function
REQ-023 States: IDLE, RD0, RD1, FILL, RESP; exactly one active.
REQ-024 Line record: line_tag (req_addr bits above line offset) and line_valid.
REQ-025 req_ready = 1 only in IDLE; handshake occurs when req_valid and req_ready are both high at a rising edge; the word address is latched.
REQ-026 Hit = line_valid and latched line tag equals line_tag; evaluated at acceptance.
REQ-027 Hit path: IDLE -> RD0 -> RD1 -> RESP; cache_addr_out = latched address in RD0 and RD1; resp_data loaded from cache_data_out at the edge leaving RD1; resp_valid high 3 cycles after the acceptance edge.
REQ-028 Miss path: IDLE -> FILL; beat counter starts at 0; mem_addr = line base + 4*beat; mem_req high throughout FILL.
REQ-029 On mem_ack in FILL (mem_err low): cache_we=1 the same cycle, cache_addr_in=mem_addr, cache_data_in=mem_rdata; beat increments; timeout counter clears.
REQ-030 When the acked beat equals the requested word offset, mem_rdata is latched into resp_data.
REQ-031 Ack on last beat (LINE_WORDS-1): line_tag set, line_valid set, -> RESP, mem_req low next cycle.
REQ-032 Timeout counter increments each FILL cycle without ack; reaching TIMEOUT, or mem_err high (takes priority over mem_ack), aborts: no cache write that cycle, line_valid cleared, resp_err=1, resp_data=0, -> RESP.
REQ-033 RESP: resp_valid=1, resp_data/resp_err stable until resp_ready; at the edge with resp_ready=1 -> IDLE, resp_valid low, resp_err cleared.
REQ-034 cache_we is 0 outside FILL-ack cycles; the block never writes the cache on a hit.
REQ-035 inv clears line_valid at the next edge in any state; inv during FILL: fill completes and writes all beats but line_valid is not set; inv in the same cycle as the last ack wins (line_valid=0).
REQ-036 A hit accepted in the same cycle as inv still uses the pre-inv line_valid.
REQ-037 Line base wraps modulo 2^32; no carry into the tag.

Reset
REQ-038 rst low: state=IDLE, line_valid=0, line_tag=0, counters=0, req_ready=0 while low, resp_valid=0, resp_err=0, resp_data=0, mem_req=0, mem_addr=0, cache_we=0, cache outputs 0.
REQ-039 Reset mid-FILL abandons the burst immediately; no further cache writes; req_ready=1 first cycle after rst rises.

Verification
REQ-040 Miss: req 0x1008 -> mem_addr 0x1000,0x1004,0x1008,0x100C with acks, 4 cache_we pulses, resp_data = word at 0x1008, resp_err=0.
REQ-041 Hit: then req 0x1004 -> no mem_req, cache_addr_out=0x1004, resp_valid exactly 3 cycles after acceptance with cache_data_out value.
REQ-042 mem_err on beat 2 of a fill -> 2 cache writes only, resp_err=1, resp_data=0; next req 0x1000 misses.
REQ-043 No mem_ack for 255 cycles -> abort at cycle 255, resp_err=1; resp_ready held low 10 cycles -> response held stable.
REQ-044 inv during fill of 0x2000 -> all 4 beats written, next req 0x2000 misses; rst low mid-fill -> mem_req=0, cache_we=0 immediately.
